// File: rtl/cpu2core_cpu0_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu2core_cpu0_dct_pkg
// Purpose  : Shared constants, types and the frame packing helper for the
//            OCI direct-control-transfer (DCT) trace packer.
// Contents : DCT_SLOTS, branch-outcome code constants, frame type, 36-bit
//            frame struct, fill state encoding, dct_pack_frame().
// Revision : 1.0 - initial release
// ============================================================================
package cpu2core_cpu0_dct_pkg;

  // Slot count is tied to the 30-bit buffer width and is fixed.
  localparam int         DCT_SLOTS      = 15;
  localparam logic [3:0] DCT_LAST_IDX   = 4'(DCT_SLOTS - 1);

  localparam logic [1:0] DCT_RSVD       = 2'b00;
  localparam logic [1:0] DCT_NT         = 2'b01;
  localparam logic [1:0] DCT_TK         = 2'b10;
  localparam logic [1:0] DCT_EXC        = 2'b11;

  localparam logic [1:0] DCT_FRAME_TYPE = 2'b01;

  typedef struct packed {
    logic [3:0]  count;
    logic [1:0]  ftype;
    logic [29:0] buffer;
  } dct_frame_t;

  typedef enum logic [0:0] {
    FILL_EMPTY  = 1'b0,
    FILL_ACTIVE = 1'b1
  } fill_state_t;

  function automatic dct_frame_t dct_pack_frame(input logic [3:0]  count,
                                                input logic [29:0] buffer);
    dct_frame_t f;
    f.count  = count;
    f.ftype  = DCT_FRAME_TYPE;
    f.buffer = buffer;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu2core_cpu0_cpu_dct_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu2core_cpu0_cpu_dct_packer_if
// Purpose  : Bundles the retire-side DCT code inputs, the buffer status
//            outputs and the trace-FIFO frame handshake of the DCT packer.
// Modports : master - retire stage / trace FIFO side (drives codes, ready,
//                     overflow_clr)
//            slave  - the packer itself
// Options  : CPU2CORE_DCT_DROP_CNT_EN adds the drop_count status signal.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu2core_cpu0_cpu_dct_packer_if;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        dct_flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic [35:0] frame_data;
  logic        frame_ready;
  logic        overflow;
  logic        overflow_clr;
`ifdef CPU2CORE_DCT_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  modport master (
    output dct_valid, dct_code, dct_flush, frame_ready, overflow_clr,
    input  dct_buffer, dct_count, frame_valid, frame_data, overflow
`ifdef CPU2CORE_DCT_DROP_CNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  dct_valid, dct_code, dct_flush, frame_ready, overflow_clr,
    output dct_buffer, dct_count, frame_valid, frame_data, overflow
`ifdef CPU2CORE_DCT_DROP_CNT_EN
    , output drop_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/cpu2core_cpu0_dct_frame_reg.sv
`default_nettype none
// ============================================================================
// Module   : cpu2core_cpu0_dct_frame_reg
// Purpose  : One-entry valid/ready holding stage for closed DCT frames.
//            A close loads the stage when it is empty or draining this
//            cycle; otherwise the new frame is discarded and drop pulses.
// Ports    : clk, reset_n        - clock, async active-low reset
//            close, frame_in     - a frame is closed this cycle
//            frame_ready         - downstream accepts the held frame
//            frame_valid/out     - held frame
//            drop                - combinational: closing frame discarded
// Revision : 1.0 - initial release
// ============================================================================
module cpu2core_cpu0_dct_frame_reg
  import cpu2core_cpu0_dct_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       close,
  input  wire dct_frame_t frame_in,
  input  wire logic       frame_ready,
  output logic            frame_valid,
  output dct_frame_t      frame_out,
  output logic            drop
);

  logic       r_valid;
  dct_frame_t r_frame;
  logic       w_load;

  // A held frame leaving this edge frees the slot for a back-to-back load.
  assign w_load = close && (!r_valid || frame_ready);
  assign drop   = close && r_valid && !frame_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_frame <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_frame <= frame_in;
    end else if (r_valid && frame_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign frame_valid = r_valid;
  assign frame_out   = r_frame;

endmodule
`default_nettype wire

// File: rtl/cpu2core_cpu0_cpu_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : cpu2core_cpu0_cpu_dct_packer
// Purpose  : Packs 2-bit branch-outcome codes into a 30-bit DCT shift buffer
//            with 4-bit fill count and emits full or flushed buffers as
//            36-bit trace frames over a valid/ready handshake.
// Ports    : clk, reset_n - clock, async active-low reset
//            bus (slave)  - dct_valid/code/flush in, dct_buffer/count out,
//                           frame_valid/data/ready handshake,
//                           overflow / overflow_clr (and drop_count)
// Options  : CPU2CORE_DCT_DROP_CNT_EN - adds saturating 8-bit drop_count.
// Revision : 1.0 - initial release
// ============================================================================
module cpu2core_cpu0_cpu_dct_packer
  import cpu2core_cpu0_dct_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset_n,
  cpu2core_cpu0_cpu_dct_packer_if.slave bus
);

  fill_state_t r_state;
  logic [29:0] r_buf;
  logic [3:0]  r_cnt;
  logic        r_overflow;

  logic        w_accept;
  logic [29:0] w_buf_next;
  logic [3:0]  w_cnt_next;
  logic        w_close;
  logic        w_drop;
  logic        w_frame_valid;
  dct_frame_t  w_frame_in;
  dct_frame_t  w_frame_out;

  assign w_accept   = bus.dct_valid && (bus.dct_code != DCT_RSVD);
  assign w_buf_next = w_accept ? {r_buf[27:0], bus.dct_code} : r_buf;
  assign w_cnt_next = r_cnt + {3'b000, w_accept};

  // FILL_ACTIVE is equivalent to r_cnt != 0, so a flush closes whenever the
  // post-accept count is non-zero. A flush together with the 15th accept
  // still yields only one close.
  assign w_close = (w_accept && (r_cnt == DCT_LAST_IDX)) ||
                   (bus.dct_flush && ((r_state == FILL_ACTIVE) || w_accept));

  assign w_frame_in = dct_pack_frame(w_cnt_next, w_buf_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL_EMPTY;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        FILL_EMPTY: begin
          if (w_close) begin
            r_buf <= '0;
            r_cnt <= '0;
          end else if (w_accept) begin
            r_state <= FILL_ACTIVE;
            r_buf   <= w_buf_next;
            r_cnt   <= w_cnt_next;
          end
        end
        FILL_ACTIVE: begin
          if (w_close) begin
            r_state <= FILL_EMPTY;
            r_buf   <= '0;
            r_cnt   <= '0;
          end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_state <= FILL_EMPTY;
          r_buf   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  cpu2core_cpu0_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .close       (w_close),
    .frame_in    (w_frame_in),
    .frame_ready (bus.frame_ready),
    .frame_valid (w_frame_valid),
    .frame_out   (w_frame_out),
    .drop        (w_drop)
  );

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef CPU2CORE_DCT_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (bus.overflow_clr) begin
      r_drop_cnt <= {7'd0, w_drop};
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.drop_count = r_drop_cnt;
`else
`endif

  assign bus.dct_buffer  = r_buf;
  assign bus.dct_count   = r_cnt;
  assign bus.frame_valid = w_frame_valid;
  assign bus.frame_data  = w_frame_out;
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/cpu2core_cpu0_cpu_dct_packer.md
# cpu2core_cpu0_cpu_dct_packer

Trace-side writer for the OCI direct-control-transfer (DCT) buffer. It packs the 2-bit branch-outcome codes retired by the CPU into a 30-bit shift buffer with a 4-bit fill count, the same `dct_buffer`/`dct_count` pair consumed by the OCI test bench. It also emits each full or flushed buffer as a 36-bit trace frame toward the trace FIFO over a valid/ready handshake. It sits between the CPU retire stage and the OCI trace FIFO.

## Interface
- `DCT_SLOTS`, default 15: 2-bit slots per frame. Fixed by buffer width; not overridable.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `dct_valid` input 1: `dct_code` is valid this cycle.
- `dct_code` input 2: 01 = not taken, 10 = taken, 11 = exception-redirect. 00 is reserved and ignored.
- `dct_flush` input 1: close the current partial frame.
- `dct_buffer` output 30: packed codes. Newest code is in bits [1:0].
- `dct_count` output 4: valid slots in `dct_buffer`, range 0..15 (15 is visible only transiently, never registered).
- `frame_valid` output 1: `frame_data` holds a frame.
- `frame_data` output 36: [35:32] = slot count, [31:30] = 2'b01 (DCT frame type), [29:0] = buffer.
- `frame_ready` input 1: downstream accepts the frame.
- `overflow` output 1: sticky flag, set when a frame is dropped.
- `overflow_clr` input 1: clears `overflow`.

## Operation
- Accept: `dct_valid` with `dct_code != 00`. The shift is `dct_buffer <= {dct_buffer[27:0], dct_code}` and `dct_count <= dct_count + 1`.
- Frame close happens on either event:
  - an accept while `dct_count == 14` (15th slot), producing count 15;
  - `dct_flush` while the post-accept count is > 0.
- On close:
  - The frame is built from the post-accept buffer and count, so an accept in the same cycle is included.
  - `dct_buffer` and `dct_count` go to 0.
- Flush with count 0 and no accept does nothing.
- Flush in the same cycle as the 15th accept produces one frame only.
- Fill state machine: EMPTY (count 0) → FILL on accept. FILL → EMPTY on close. FILL stays in FILL otherwise.
- Output register: a one-entry holding stage.
  - It loads on close when it is empty, or when `frame_valid && frame_ready` in the same cycle (back-to-back).
  - If a close occurs while `frame_valid && !frame_ready`, the new frame is dropped, `overflow` sets, and the held frame stays unchanged.
  - Packing never stalls: the buffer always clears on close, whether the frame is loaded or dropped.
- `overflow_clr` clears the flag. If a set and a clear happen in the same cycle, the set wins.
- `frame_data` is stable while `frame_valid && !frame_ready`.

## Timing
- Reset values: `dct_buffer` = 0, `dct_count` = 0, `frame_valid` = 0, `frame_data` = 0, `overflow` = 0.
- `dct_buffer` and `dct_count` update on the edge after an accept.
- `frame_valid` rises on the edge after the closing input cycle, giving 1-cycle latency.
- A frame transfers on any edge where `frame_valid && frame_ready`. `frame_valid` falls on that edge unless a new close loads it.
- Throughput: one frame per cycle is sustainable when `frame_ready` is held high.
- Reset asserted mid-frame discards the partial buffer and the held frame. No frame is emitted on reset release.

## Configuration
- `CPU2CORE_DCT_DROP_CNT_EN`:
  - Defined: adds output `drop_count` [7:0]. It counts dropped frames, saturates at 255, resets to 0, and is cleared by `overflow_clr`. A clear and a drop in the same cycle gives 1.
  - Undefined: the port and counter are absent. `overflow` behaviour is unchanged.

## Structure
- Package `cpu2core_cpu0_dct_pkg` holds:
  - `DCT_SLOTS`;
  - the code constants `DCT_NT`, `DCT_TK`, `DCT_EXC`;
  - `DCT_FRAME_TYPE` = 2'b01;
  - the frame packing function;
  - a packed struct typedef for the 36-bit frame.
- Sub-module `cpu2core_cpu0_dct_frame_reg`: the one-entry valid/ready holding register with drop detection. The packing and fill state machine stay in the top.

## Test plan
- Reset, then 15 accepts of code 10 with `frame_ready` = 1 → one frame with `frame_data` = 36'hF_6AAA_AAAA (count F, type 01, buffer all 10). `dct_count` returns to 0 the cycle after.
- Three accepts of 01, 10, 11, then `dct_flush` → frame [35:32] = 3, [29:0] = 30'h1B. A flush at count 0 produces no frame.
- Accepts with code 00 interleaved → ignored, `dct_count` unchanged.
- Hold `frame_ready` = 0 and close two frames → the first frame is held, the second is dropped, `overflow` = 1, and `drop_count` = 1 when the macro is enabled. Then raise `frame_ready` → the first frame is delivered.
- Flush in the same cycle as the 14th accept → a single frame with count 14 (4'hE). Flush in the same cycle as the 15th accept → a single frame with count 15.
- Assert `reset_n` low at count 7 while a frame is held → all outputs are 0 immediately, and no frame appears after release.
